serdesphy_pll_cal_ctrl: RTL

SERDESPHY_PLL_CAL_CTRL -- requirements
Module: serdesphy_pll_cal_ctrl

---
 rtl/serdesphy_pll_cal_ctrl.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/serdesphy_pll_cal_ctrl.sv
// SerDes PHY PLL bring-up and VCO trim calibration controller.
// Holds the PLL in reset, waits for a qualified lock, optionally sweeps the
// VCO trim code upward on timeout, and watches for loss of lock afterwards.
module serdesphy_pll_cal_ctrl #(
    parameter int         RST_CYCLES   = 8,
    parameter int         LOCK_TIMEOUT = 512,
    parameter int         LOCK_STABLE  = 4,
    parameter logic [1:0] CP_DEFAULT   = 2'b10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       cal_en,
    input  logic [3:0] trim_start,
    input  logic       pll_lock_in,
    output logic       pll_enable,
    output logic       pll_rst,
    output logic [3:0] vco_trim,
    output logic [1:0] cp_current,
    output logic       busy,
    output logic       done,
    output logic       fail,
    output logic       lock_lost
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PWRUP     = 3'd1,
        WAIT_LOCK = 3'd2,
        NEXT_TRIM = 3'd3,
        LOCKED    = 3'd4,
        FAIL      = 3'd5
    } state_t;

    localparam int CW = 16;
    localparam logic [CW-1:0] RST_LAST     = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE - 1);

    state_t          r_state;
    logic            r_syncMeta;
    logic            r_lockSync;
    logic [CW-1:0]   r_cycleCnt;
    logic [CW-1:0]   r_stableCnt;

    // Output pattern {pll_enable, pll_rst, busy, done, fail} for the state being entered,
    // so every output is registered together with the state it belongs to.
    function automatic logic [4:0] outsFor(input state_t s);
        case (s)
            PWRUP:     outsFor = 5'b11100;
            WAIT_LOCK: outsFor = 5'b10100;
            NEXT_TRIM: outsFor = 5'b11100;
            LOCKED:    outsFor = 5'b10010;
            FAIL:      outsFor = 5'b01001;
            default:   outsFor = 5'b01000;
        endcase
    endfunction

    // Two-flop synchronizer for the lock indicator coming from the PLL domain.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_syncMeta <= 1'b0;
            r_lockSync <= 1'b0;
        end else begin
            r_syncMeta <= pll_lock_in;
            r_lockSync <= r_syncMeta;
        end
    end

    // Charge pump code is a fixed strap, held in a register so it is glitch free.
    always_ff @(posedge clk) begin
        cp_current <= CP_DEFAULT;
    end

    // Bring-up FSM; counters are zeroed on every state entry and stop overrides everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            {pll_enable, pll_rst, busy, done, fail} <= outsFor(IDLE);
            vco_trim    <= 4'h0;
            lock_lost   <= 1'b0;
            r_cycleCnt  <= '0;
            r_stableCnt <= '0;
        end else begin
            lock_lost <= 1'b0;
            if (stop) begin
                r_state     <= IDLE;
                {pll_enable, pll_rst, busy, done, fail} <= outsFor(IDLE);
                r_cycleCnt  <= '0;
                r_stableCnt <= '0;
            end else begin
                case (r_state)
                    IDLE, FAIL: begin
                        if (start) begin
                            vco_trim    <= trim_start;
                            r_state     <= PWRUP;
                            {pll_enable, pll_rst, busy, done, fail} <= outsFor(PWRUP);
                            r_cycleCnt  <= '0;
                            r_stableCnt <= '0;
                        end
                    end
                    PWRUP: begin
                        if (r_cycleCnt == RST_LAST) begin
                            r_state     <= WAIT_LOCK;
                            {pll_enable, pll_rst, busy, done, fail} <= outsFor(WAIT_LOCK);
                            r_cycleCnt  <= '0;
                            r_stableCnt <= '0;
                        end else begin
                            r_cycleCnt <= r_cycleCnt + 1'b1;
                        end
                    end
                    WAIT_LOCK: begin
                        if (r_lockSync && (r_stableCnt == STABLE_LAST)) begin
                            r_state     <= LOCKED;
                            {pll_enable, pll_rst, busy, done, fail} <= outsFor(LOCKED);
                            r_cycleCnt  <= '0;
                            r_stableCnt <= '0;
                        end else if (r_cycleCnt == TIMEOUT_LAST) begin
                            r_state     <= cal_en ? NEXT_TRIM : FAIL;
                            {pll_enable, pll_rst, busy, done, fail} <=
                                outsFor(cal_en ? NEXT_TRIM : FAIL);
                            r_cycleCnt  <= '0;
                            r_stableCnt <= '0;
                        end else begin
                            r_cycleCnt  <= r_cycleCnt + 1'b1;
                            r_stableCnt <= r_lockSync ? r_stableCnt + 1'b1 : '0;
                        end
                    end
                    NEXT_TRIM: begin
                        r_cycleCnt  <= '0;
                        r_stableCnt <= '0;
                        if (vco_trim == 4'hF) begin
                            r_state <= FAIL;
                            {pll_enable, pll_rst, busy, done, fail} <= outsFor(FAIL);
                        end else begin
                            vco_trim <= vco_trim + 4'h1;
                            r_state  <= PWRUP;
                            {pll_enable, pll_rst, busy, done, fail} <= outsFor(PWRUP);
                        end
                    end
                    LOCKED: begin
                        if (!r_lockSync && (r_stableCnt == STABLE_LAST)) begin
                            lock_lost   <= 1'b1;
                            r_state     <= PWRUP;
                            {pll_enable, pll_rst, busy, done, fail} <= outsFor(PWRUP);
                            r_cycleCnt  <= '0;
                            r_stableCnt <= '0;
                        end else begin
                            r_stableCnt <= r_lockSync ? '0 : r_stableCnt + 1'b1;
                        end
                    end
                    default: begin
                        r_state     <= IDLE;
                        {pll_enable, pll_rst, busy, done, fail} <= outsFor(IDLE);
                        r_cycleCnt  <= '0;
                        r_stableCnt <= '0;
                    end
                endcase
            end
        end
    end

endmodule
